score_accumulator: RTL and testbench
====================================

SCORE_ACCUMULATOR -- requirements
Module: score_accumulator

Interface
REQ-001 SHALL have parameter TIME_W, default 7, width of time input in seconds.
REQ-002 SHALL have parameter BUCKET, default 10, seconds per score step (>=1).
REQ-003 SHALL have parameter MAX_SCORE, default 9, score for time < BUCKET.
REQ-004 SHALL have parameter MIN_SCORE, default 1, score floor (0 <= MIN_SCORE <= MAX_SCORE).
REQ-005 SHALL have parameter ROUNDS, default 3, rounds per game (>=1).
REQ-006 SHALL have parameter SCORE_W, default 4, score width, able to hold MAX_SCORE.
REQ-007 SHALL have parameter TOTAL_W, default 6, total width, able to hold ROUNDS*MAX_SCORE.
REQ-008 SHALL have port clk, input, 1, single clock; one clock, all logic on rising edge.
REQ-009 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-010 SHALL have port clear, input, 1, synchronous game clear.
REQ-011 SHALL have port in_valid, input, 1, time_count is valid.
REQ-012 SHALL have port time_count, input, TIME_W, finished-round time in seconds.
REQ-013 SHALL have port in_ready, output, 1, block can accept a time.
REQ-014 SHALL have port score, output, SCORE_W, last computed round score.
REQ-015 SHALL have port score_valid, output, 1, one-cycle pulse when score updates.
REQ-016 SHALL have port total, output, TOTAL_W, sum of scores this game.
REQ-017 SHALL have port best, output, SCORE_W, highest round score this game.
REQ-018 SHALL have port round_cnt, output, $clog2(ROUNDS+1), rounds completed.
REQ-019 SHALL have port game_done, output, 1, level, ROUNDS rounds completed.

Function
REQ-020 SHALL compute score = max(MIN_SCORE, MAX_SCORE - floor(time_count/BUCKET)), with no divider.
REQ-021 SHALL implement FSM states IDLE and CALC.
REQ-022 SHALL drive in_ready = (state==IDLE) & !game_done, combinationally.
REQ-023 SHALL accept on the edge where in_valid & in_ready & !clear: latch rem=time_count, work=MAX_SCORE, go to CALC.
REQ-024 On each CALC edge with rem>=BUCKET and work>MIN_SCORE, SHALL apply rem-=BUCKET, work-=1 and stay in CALC.
REQ-025 On a CALC edge with the condition false, SHALL register score=work, pulse score_valid, total+=work, round_cnt+=1, best=max(best,work), and return to IDLE.
REQ-026 Latency: with k = min(floor(t/BUCKET), MAX_SCORE-MIN_SCORE), score_valid SHALL be high after exactly k+1 edges following the accepting edge, and SHALL be high for one cycle only.
REQ-027 SHALL set game_done when round_cnt reaches ROUNDS and hold it until clear or rst; in_valid SHALL be ignored while game_done=1.
REQ-028 SHALL hold score and best between updates, and SHALL never wrap total (guaranteed by TOTAL_W).
REQ-029 clear SHALL have priority over acceptance and completion: on a clear edge, total, best, round_cnt, score and game_done SHALL be 0, state SHALL be IDLE, and no score_valid pulse SHALL occur.
REQ-030 clear during CALC SHALL abort the calculation with no score_valid pulse.
REQ-031 Boundaries at default params: t=9->9, t=10->8, t=79->2, t=80->1, t=127->1 (clamped at MIN_SCORE).

Reset
REQ-032 On a rst edge, SHALL set state=IDLE, score=0, score_valid=0, total=0, best=0, round_cnt=0, game_done=0; rst SHALL dominate clear and in_valid.
REQ-033 rst asserted mid-CALC SHALL discard the calculation; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 After rst, t=0 accepted -> score_valid 1 edge later, score=9, total=9, best=9, round_cnt=1.
REQ-035 t=25 -> score=7 after 3 edges; t=95 -> score=1 after 9 edges; t=127 -> score=1 after 9 edges, in_ready=0 throughout CALC.
REQ-036 Rounds t=5,45,89 -> scores 9,5,1, total=15, best=9, game_done=1, in_ready=0; a fourth in_valid produces no pulse and no change.
REQ-037 t=80 accepted, clear 3 edges later -> no score_valid, total=0, round_cnt=0, in_ready=1 next cycle.
REQ-038 clear and in_valid (t=0) on the same edge -> not accepted, no score_valid within 5 cycles.
REQ-039 rst during CALC of t=60 after a prior round -> all outputs 0, and the next t=0 yields score=9, total=9.

Source files
------------

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - per-round time-to-score converter with game total, best and round tracking
//
// Purpose: converts each finished-round time (seconds) into a score of
//   max(MIN_SCORE, MAX_SCORE - floor(time/BUCKET)) by repeated subtraction,
//   and accumulates total, best score and round count over a game of ROUNDS rounds.
//
// Ports:
//   clk         in   single rising-edge clock
//   rst         in   synchronous active-high reset, dominates everything
//   clear       in   synchronous game clear, dominates acceptance and completion
//   in_valid    in   time_count is valid
//   time_count  in   finished-round time in seconds
//   in_ready    out  block can accept a time (IDLE and game not done)
//   score       out  last computed round score
//   score_valid out  one-cycle pulse when score updates
//   total       out  sum of scores this game
//   best        out  highest round score this game
//   round_cnt   out  rounds completed this game
//   game_done   out  level, ROUNDS rounds completed
module score_accumulator #(
  parameter int TIME_W    = 7,
  parameter int BUCKET    = 10,
  parameter int MAX_SCORE = 9,
  parameter int MIN_SCORE = 1,
  parameter int ROUNDS    = 3,
  parameter int SCORE_W   = 4,
  parameter int TOTAL_W   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [TIME_W-1:0]            time_count,
  output logic                         in_ready,
  output logic [SCORE_W-1:0]           score,
  output logic                         score_valid,
  output logic [TOTAL_W-1:0]           total,
  output logic [SCORE_W-1:0]           best,
  output logic [$clog2(ROUNDS+1)-1:0]  round_cnt,
  output logic                         game_done
);

  localparam int CNT_W = $clog2(ROUNDS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             r_state;
  logic [TIME_W-1:0]  r_rem;
  logic [SCORE_W-1:0] r_work;
  logic [SCORE_W-1:0] r_score;
  logic               r_score_valid;
  logic [TOTAL_W-1:0] r_total;
  logic [SCORE_W-1:0] r_best;
  logic [CNT_W-1:0]   r_round_cnt;
  logic               r_game_done;

  logic w_step;

  // One more bucket can be taken off only while the remainder still covers
  // a full bucket and the score has not yet hit its floor.
  assign w_step   = (int'(r_rem) >= BUCKET) && (int'(r_work) > MIN_SCORE);
  assign in_ready = (r_state == IDLE) && !r_game_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_work        <= '0;
      r_score       <= '0;
      r_score_valid <= 1'b0;
      r_total       <= '0;
      r_best        <= '0;
      r_round_cnt   <= '0;
      r_game_done   <= 1'b0;
    end else begin
      r_score_valid <= 1'b0;
      if (clear) begin
        r_state     <= IDLE;
        r_score     <= '0;
        r_total     <= '0;
        r_best      <= '0;
        r_round_cnt <= '0;
        r_game_done <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (in_valid && in_ready) begin
              r_rem   <= time_count;
              r_work  <= SCORE_W'(MAX_SCORE);
              r_state <= CALC;
            end
          end
          CALC: begin
            if (w_step) begin
              r_rem  <= r_rem - TIME_W'(BUCKET);
              r_work <= r_work - SCORE_W'(1);
            end else begin
              r_score       <= r_work;
              r_score_valid <= 1'b1;
              r_total       <= r_total + TOTAL_W'(r_work);
              r_round_cnt   <= r_round_cnt + CNT_W'(1);
              if (r_work > r_best) begin
                r_best <= r_work;
              end
              if (int'(r_round_cnt) == ROUNDS - 1) begin
                r_game_done <= 1'b1;
              end
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign score       = r_score;
  assign score_valid = r_score_valid;
  assign total       = r_total;
  assign best        = r_best;
  assign round_cnt   = r_round_cnt;
  assign game_done   = r_game_done;

endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - directed scoreboard bench for score_accumulator
module tb_score_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] time_count = '0;
  logic       in_ready;
  logic [3:0] score;
  logic       score_valid;
  logic [5:0] total;
  logic [3:0] best;
  logic [1:0] round_cnt;
  logic       game_done;

  score_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .time_count (time_count),
    .in_ready   (in_ready),
    .score      (score),
    .score_valid(score_valid),
    .total      (total),
    .best       (best),
    .round_cnt  (round_cnt),
    .game_done  (game_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int total;
    int best;
    int rounds;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_total  = 0;
  int   m_best   = 0;
  int   m_rounds = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_total  = 0;
    m_best   = 0;
    m_rounds = 0;
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_total"}, int'(total), 0);
    chk({tag, "_best"}, int'(best), 0);
    chk({tag, "_rcnt"}, int'(round_cnt), 0);
    chk({tag, "_done"}, int'(game_done), 0);
    chk({tag, "_valid"}, int'(score_valid), 0);
  endtask

  task automatic no_pulse(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk(tag, int'(score_valid), 0);
    end
  endtask

  // Drive one time, push the model's expectation, then wait for the pulse
  // and compare latency and all outputs against the popped entry.
  task automatic play(input int t);
    exp_t e;
    exp_t got;
    int   k;
    int   n;
    int   s;
    s = 9 - t / 10;
    if (s < 1) s = 1;
    k = t / 10;
    if (k > 8) k = 8;
    m_total  += s;
    m_rounds += 1;
    if (s > m_best) m_best = s;
    e.score  = s;
    e.total  = m_total;
    e.best   = m_best;
    e.rounds = m_rounds;
    e.lat    = k + 1;
    exp_q.push_back(e);

    @(negedge clk);
    chk($sformatf("ready_t%0d", t), int'(in_ready), 1);
    in_valid   = 1'b1;
    time_count = 7'(t);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (score_valid === 1'b1) begin
        n = i;
        break;
      end
      chk($sformatf("calc_ready_t%0d", t), int'(in_ready), 0);
    end
    if (n == 0) begin
      chk($sformatf("timeout_t%0d", t), 0, 1);
      void'(exp_q.pop_front());
    end else begin
      got = exp_q.pop_front();
      chk($sformatf("lat_t%0d", t), n, got.lat);
      chk($sformatf("score_t%0d", t), int'(score), got.score);
      chk($sformatf("total_t%0d", t), int'(total), got.total);
      chk($sformatf("best_t%0d", t), int'(best), got.best);
      chk($sformatf("rcnt_t%0d", t), int'(round_cnt), got.rounds);
      chk($sformatf("done_t%0d", t), int'(game_done), (got.rounds == 3) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("pulse1_t%0d", t), int'(score_valid), 0);
      chk($sformatf("hold_t%0d", t), int'(score), got.score);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    chk("rst_ready", int'(in_ready), 1);
    model_clear();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_zero("clr");
    chk("clr_ready", int'(in_ready), 1);
    model_clear();
  endtask

  initial begin
    do_reset();

    // single round from reset
    play(0);

    // 25, 95, 127 make up a full game
    do_clear();
    play(25);
    play(95);
    play(127);
    chk("g1_total", int'(total), 9);
    chk("g1_best", int'(best), 7);
    chk("g1_ready", int'(in_ready), 0);

    // 5, 45, 89 then an ignored fourth time
    do_clear();
    play(5);
    play(45);
    play(89);
    chk("g2_total", int'(total), 15);
    chk("g2_best", int'(best), 9);
    chk("g2_done", int'(game_done), 1);
    chk("g2_ready", int'(in_ready), 0);
    @(negedge clk);
    in_valid   = 1'b1;
    time_count = 7'd0;
    no_pulse("g2_fourth_pulse", 12);
    in_valid = 1'b0;
    chk("g2_fourth_total", int'(total), 15);
    chk("g2_fourth_rcnt", int'(round_cnt), 3);
    chk("g2_fourth_score", int'(score), 1);

    // clear 3 edges after accepting t=80 aborts the calculation
    do_clear();
    @(negedge clk);
    in_valid   = 1'b1;
    time_count = 7'd80;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort_valid", int'(score_valid), 0);
    chk("abort_ready", int'(in_ready), 1);
    no_pulse("abort_pulse", 12);
    chk("abort_total", int'(total), 0);
    chk("abort_rcnt", int'(round_cnt), 0);

    // clear and in_valid on the same edge: not accepted
    @(negedge clk);
    clear      = 1'b1;
    in_valid   = 1'b1;
    time_count = 7'd0;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clrval_ready", int'(in_ready), 1);
    no_pulse("clrval_pulse", 5);
    chk("clrval_rcnt", int'(round_cnt), 0);

    // score boundaries
    do_clear();
    play(9);
    play(10);
    play(79);
    do_clear();
    play(80);
    play(127);

    // reset during a calculation after a prior round
    do_clear();
    play(0);
    @(negedge clk);
    in_valid   = 1'b1;
    time_count = 7'd60;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    chk("midrst_ready", int'(in_ready), 1);
    model_clear();
    no_pulse("midrst_pulse", 10);
    play(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "bench time limit reached");
  end

endmodule
